// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-style control unit: Moore FSM whose datapath controls are
// registered alongside the state, plus a combinational PC load enable.
module multi_cycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               PCEn,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               ExtZero,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         PCSource,
    output logic [3:0]         ALUCtr,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = STATE_W'(4'd15),
        S_FETCH  = STATE_W'(4'd0),
        S_DECODE = STATE_W'(4'd1),
        S_MEMADR = STATE_W'(4'd2),
        S_MEMRD  = STATE_W'(4'd3),
        S_MEMWB  = STATE_W'(4'd4),
        S_MEMWR  = STATE_W'(4'd5),
        S_EXEC   = STATE_W'(4'd6),
        S_ALUWB  = STATE_W'(4'd7),
        S_BRANCH = STATE_W'(4'd8),
        S_JUMP   = STATE_W'(4'd9),
        S_IEXEC  = STATE_W'(4'd10),
        S_IWB    = STATE_W'(4'd11)
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_zero;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [3:0] alu_ctr;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam ctrl_t CTRL_DEFAULT = '{
        pc_write:      1'b0,
        pc_write_cond: 1'b0,
        iord:          1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        ir_write:      1'b0,
        mem_to_reg:    1'b0,
        reg_dst:       1'b0,
        reg_write:     1'b0,
        alu_src_a:     1'b0,
        ext_zero:      1'b0,
        alu_src_b:     2'b00,
        pc_source:     2'b00,
        alu_ctr:       ALU_ADD
    };

    // Returns {legal, alu_ctr} for an R-type function field.
    function automatic logic [4:0] funct_dec(input logic [5:0] fn);
        case (fn)
            6'b100000, 6'b100001: return {1'b1, 4'b0010};
            6'b100010, 6'b100011: return {1'b1, 4'b0110};
            6'b100100:            return {1'b1, 4'b0000};
            6'b100101:            return {1'b1, 4'b0001};
            6'b100110:            return {1'b1, 4'b1001};
            6'b100111:            return {1'b1, 4'b1100};
            6'b101010:            return {1'b1, 4'b0111};
            6'b101011:            return {1'b1, 4'b1010};
            6'b000100:            return {1'b1, 4'b0101};
            6'b000111:            return {1'b1, 4'b1000};
            6'b011010:            return {1'b1, 4'b0011};
            6'b011000:            return {1'b1, 4'b0100};
            default:              return {1'b0, ALU_ADD};
        endcase
    endfunction

    // Control word for a given state; opcode/funct are stable while IRWrite=0.
    function automatic ctrl_t ctrl_dec(input state_e st, input logic [5:0] op,
                                       input logic [5:0] fn);
        ctrl_t      c;
        logic [4:0] fd;
        c  = CTRL_DEFAULT;
        fd = funct_dec(fn);
        case (st)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.pc_source = 2'b00;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_ctr   = fd[3:0];
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = 2'b00;
                c.alu_ctr       = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            S_IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                if (op == OP_ORI) begin
                    c.alu_ctr  = ALU_OR;
                    c.ext_zero = 1'b1;
                end else begin
                    c.alu_ctr  = ALU_ADD;
                    c.ext_zero = 1'b0;
                end
            end
            S_IWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b0;
            end
            default: c = CTRL_DEFAULT;
        endcase
        return c;
    endfunction

    state_e     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       illegal_q, illegal_d;
    logic [4:0] funct_info_s;

    assign funct_info_s = funct_dec(Funct);

    // Next-state selection and illegal-instruction detection.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_ADDI, OP_ORI:  state_d = S_IEXEC;
                    OP_RTYPE: begin
                        if (funct_info_s[4]) begin
                            state_d = S_EXEC;
                        end else begin
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_IEXEC:  state_d = S_IWB;
            S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
        ctrl_d = ctrl_dec(state_d, Opcode, Funct);
    end

    // State, control word and Illegal pulse; reset clears them asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= CTRL_DEFAULT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= illegal_d;
        end
    end

    assign PCEn     = ctrl_q.pc_write | (ctrl_q.pc_write_cond & Zero);
    assign IorD     = ctrl_q.iord;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign IRWrite  = ctrl_q.ir_write;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegDst   = ctrl_q.reg_dst;
    assign RegWrite = ctrl_q.reg_write;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign ExtZero  = ctrl_q.ext_zero;
    assign ALUSrcB  = ctrl_q.alu_src_b;
    assign PCSource = ctrl_q.pc_source;
    assign ALUCtr   = ctrl_q.alu_ctr;
    assign Illegal  = illegal_q;
    assign State    = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl: walks each instruction
// class through its state sequence and checks the decoded controls.
module tb_multi_cycle_ctrl;

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, MemtoReg;
    logic       RegDst, RegWrite, ALUSrcA, ExtZero, Illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUCtr;
    logic [3:0] State;

    int n_cmp;
    int n_bad;

    logic [5:0] fn_tab  [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                                 6'b101010, 6'b101011, 6'b000100, 6'b000111,
                                 6'b011010, 6'b011000};
    logic [3:0] ctr_tab [14] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h9, 4'hC,
                                 4'h7, 4'hA, 4'h5, 4'h8, 4'h3, 4'h4};

    multi_cycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ExtZero(ExtZero),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUCtr(ALUCtr),
        .Illegal(Illegal), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock and check the state reached.
    task automatic go(input string tag, input logic [3:0] exp_state);
        @(posedge clk);
        @(negedge clk);
        check_val(tag, {28'd0, State}, {28'd0, exp_state});
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        Opcode = 6'b000000;
        Funct  = 6'b100000;
        Zero   = 1'b0;

        repeat (2) @(negedge clk);
        check_val("rst_state", {28'd0, State}, 32'd15);
        check_val("rst_enables", {27'd0, PCEn, MemRead, MemWrite, IRWrite, RegWrite}, 32'd0);
        check_val("rst_muxes", {20'd0, ALUSrcB, PCSource, IorD, MemtoReg, RegDst,
                                ALUSrcA, ExtZero, Illegal}, 32'd0);
        check_val("rst_aluctr", {28'd0, ALUCtr}, 32'd2);

        rst_n = 1'b1;
        #1;
        check_val("idle_after_rel", {28'd0, State}, 32'd15);
        check_val("idle_enables", {29'd0, PCEn, IRWrite, MemRead}, 32'd0);
        @(negedge clk);
        check_val("first_fetch", {28'd0, State}, 32'd0);
        check_val("fetch_enables", {29'd0, PCEn, IRWrite, MemRead}, 32'd7);
        check_val("fetch_srcb", {30'd0, ALUSrcB}, 32'd1);

        // lw
        Opcode = 6'b100011;
        go("lw_s1", 4'd1);
        check_val("decode_pcen", {31'd0, PCEn}, 32'd0);
        check_val("decode_srcb", {30'd0, ALUSrcB}, 32'd3);
        go("lw_s2", 4'd2);
        check_val("memadr_ctl", {29'd0, ALUSrcA, ALUSrcB}, 32'h6);
        go("lw_s3", 4'd3);
        check_val("memrd_ctl", {30'd0, MemRead, IorD}, 32'd3);
        go("lw_s4", 4'd4);
        check_val("memwb_ctl", {30'd0, MemtoReg, RegWrite}, 32'd3);
        go("lw_s0", 4'd0);

        // sw
        Opcode = 6'b101011;
        go("sw_s1", 4'd1);
        go("sw_s2", 4'd2);
        check_val("sw_nowrite_adr", {31'd0, MemWrite}, 32'd0);
        go("sw_s5", 4'd5);
        check_val("memwr_ctl", {30'd0, MemWrite, IorD}, 32'd3);
        go("sw_s0", 4'd0);
        check_val("sw_write_off", {31'd0, MemWrite}, 32'd0);

        // R-type sweep
        Opcode = 6'b000000;
        for (int i = 0; i < 14; i++) begin
            Funct = fn_tab[i];
            go("r_s1", 4'd1);
            go("r_s6", 4'd6);
            check_val($sformatf("r_aluctr_%0d", i), {28'd0, ALUCtr}, {28'd0, ctr_tab[i]});
            check_val("r_exec_src", {29'd0, ALUSrcA, ALUSrcB}, 32'h4);
            go("r_s7", 4'd7);
            check_val("r_aluwb", {30'd0, RegDst, RegWrite}, 32'd3);
            go("r_s0", 4'd0);
            check_val("r_no_illegal", {31'd0, Illegal}, 32'd0);
        end

        // illegal funct
        Funct = 6'b001000;
        go("ilf_s1", 4'd1);
        check_val("ilf_regw_dec", {31'd0, RegWrite}, 32'd0);
        go("ilf_s0", 4'd0);
        check_val("ilf_illegal", {31'd0, Illegal}, 32'd1);
        check_val("ilf_regw_fetch", {31'd0, RegWrite}, 32'd0);

        // jump, also checks Illegal drops after one cycle
        Opcode = 6'b000010;
        go("j_s1", 4'd1);
        check_val("illegal_pulse_end", {31'd0, Illegal}, 32'd0);
        go("j_s9", 4'd9);
        check_val("jump_ctl", {29'd0, PCEn, PCSource}, 32'h6);
        go("j_s0", 4'd0);

        // illegal opcode
        Opcode = 6'b111111;
        go("ilo_s1", 4'd1);
        go("ilo_s0", 4'd0);
        check_val("ilo_illegal", {31'd0, Illegal}, 32'd1);

        // beq taken then not taken
        Opcode = 6'b000100;
        Zero   = 1'b1;
        go("beq_s1", 4'd1);
        go("beq_s8", 4'd8);
        check_val("beq_z1_pcen", {31'd0, PCEn}, 32'd1);
        check_val("beq_aluctr", {28'd0, ALUCtr}, 32'd6);
        check_val("beq_pcsrc", {30'd0, PCSource}, 32'd1);
        Zero = 1'b0;
        #1;
        check_val("beq_z0_comb", {31'd0, PCEn}, 32'd0);
        go("beq_s0", 4'd0);
        go("beq2_s1", 4'd1);
        go("beq2_s8", 4'd8);
        check_val("beq_z0_pcen", {31'd0, PCEn}, 32'd0);
        check_val("beq2_aluctr", {28'd0, ALUCtr}, 32'd6);
        go("beq2_s0", 4'd0);

        // ori
        Opcode = 6'b001101;
        go("ori_s1", 4'd1);
        go("ori_s10", 4'd10);
        check_val("ori_ext", {31'd0, ExtZero}, 32'd1);
        check_val("ori_aluctr", {28'd0, ALUCtr}, 32'd1);
        check_val("ori_srcb", {30'd0, ALUSrcB}, 32'd2);
        go("ori_s11", 4'd11);
        check_val("iwb_ctl", {30'd0, RegWrite, RegDst}, 32'd2);
        go("ori_s0", 4'd0);

        // addi
        Opcode = 6'b001000;
        go("addi_s1", 4'd1);
        go("addi_s10", 4'd10);
        check_val("addi_ext", {31'd0, ExtZero}, 32'd0);
        check_val("addi_aluctr", {28'd0, ALUCtr}, 32'd2);
        go("addi_s11", 4'd11);
        go("addi_s0", 4'd0);

        // reset asserted between edges during MEMWR
        Opcode = 6'b101011;
        go("swr_s1", 4'd1);
        go("swr_s2", 4'd2);
        go("swr_s5", 4'd5);
        check_val("swr_memwrite", {31'd0, MemWrite}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_memwrite", {31'd0, MemWrite}, 32'd0);
        check_val("async_state", {28'd0, State}, 32'd15);
        check_val("async_iord", {31'd0, IorD}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rec_idle", {28'd0, State}, 32'd15);
        check_val("rec_idle_en", {27'd0, PCEn, MemRead, MemWrite, IRWrite, RegWrite}, 32'd0);
        @(negedge clk);
        check_val("rec_fetch", {28'd0, State}, 32'd0);
        check_val("rec_fetch_en", {29'd0, PCEn, IRWrite, MemRead}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 The block SHALL have parameter STATE_W, default 4, giving the width of the state register and the State debug output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 Funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 Zero  input  1  ALU zero flag, sampled only in BRANCH.
REQ-007 PCEn  output  1  PC load enable.
REQ-008 IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ExtZero  outputs  1 each  datapath controls (ExtZero=1 zero-extends imm16).
REQ-009 ALUSrcB  output  2  00 reg B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2.
REQ-010 PCSource  output  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 ALUCtr  output  4  ALU operation code (REQ-016).
REQ-012 Illegal  output  1  one-cycle pulse on an undecodable instruction.
REQ-013 State  output  STATE_W  current state, for debug.

Function
REQ-014 States SHALL be: IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Codes 12-14 are unused and SHALL go to FETCH.
REQ-015 Transitions:
- IDLE->FETCH->DECODE.
- DECODE by Opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 with a legal Funct -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 000010 (j) -> JUMP.
  - 001000 (addi) or 001101 (ori) -> IEXEC.
  - anything else -> FETCH with Illegal=1.
- MEMADR->MEMRD if lw, MEMWR if sw.
- MEMRD->MEMWB.
- EXEC->ALUWB; IEXEC->IWB.
- MEMWB, MEMWR, ALUWB, BRANCH, JUMP, IWB -> FETCH.
REQ-016 ALUCtr encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 DIV, 0100 MUL, 0101 SLLV, 0110 SUB, 0111 SLT, 1000 SRAV, 1001 XOR, 1010 SLTU, 1100 NOR.
REQ-017 Legal Funct to ALUCtr mapping:
- 100000/100001 -> 0010; 100010/100011 -> 0110.
- 100100 -> 0000; 100101 -> 0001; 100110 -> 1001; 100111 -> 1100.
- 101010 -> 0111; 101011 -> 1010.
- 000100 -> 0101; 000111 -> 1000.
- 011010 -> 0011; 011000 -> 0100.
- Every other Funct is illegal (DECODE->FETCH, Illegal=1).
REQ-018 Outputs SHALL be decoded from the registered state and the instruction fields. Every control not listed is 0 and ALUCtr defaults to 0010.
- FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01, PCSource=00.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA, ALUSrcB=10.
- MEMRD: MemRead, IorD.
- MEMWB: RegWrite, MemtoReg.
- MEMWR: MemWrite, IorD.
- EXEC: ALUSrcA, ALUSrcB=00, ALUCtr per REQ-017.
- ALUWB: RegWrite, RegDst.
- BRANCH: ALUSrcA, ALUSrcB=00, ALUCtr=0110, PCWriteCond, PCSource=01.
- JUMP: PCWrite, PCSource=10.
- IEXEC: ALUSrcA, ALUSrcB=10, ALUCtr=0010 for addi, 0001 with ExtZero=1 for ori.
- IWB: RegWrite, RegDst=0.
REQ-019 PCEn SHALL equal PCWrite OR (PCWriteCond AND Zero), evaluated combinationally in the same cycle.
REQ-020 In EXEC/ALUWB and IEXEC/IWB, ALUCtr, ExtZero and RegDst SHALL follow the Opcode and Funct held stable by the instruction register; IRWrite=0 guarantees this.
REQ-021 Illegal SHALL be registered: high for exactly the FETCH cycle following the offending DECODE.
REQ-022 Latency in cycles, FETCH to FETCH: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3, illegal 2.

Reset
REQ-023 While rst_n=0: State=IDLE, Illegal=0, and all enables are 0 (PCEn, MemRead, MemWrite, IRWrite, RegWrite). Muxes are 0 and ALUCtr=0010.
REQ-024 Asserting rst_n mid-instruction SHALL force IDLE immediately, with no clock needed. Any write enable, including MemWrite in MEMWR, SHALL drop in the same delta.
REQ-025 After rst_n rises, exactly one IDLE cycle with all enables 0 SHALL precede the first FETCH.

Verification
REQ-026 Reset release -> State 15 for one cycle, then 0; PCEn=1, IRWrite=1 and MemRead=1 only in the FETCH cycle.
REQ-027 lw (Opcode 100011) -> states 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 in state 4; the sw variant gives 0,1,2,5,0 with MemWrite=1 only in state 5.
REQ-028 R-type sweep, all 14 legal Funct values -> ALUCtr in EXEC matches REQ-017 and RegDst=1 in ALUWB; Funct 001000 -> Illegal=1 in the next FETCH and RegWrite never asserted.
REQ-029 beq with Zero=1 -> PCEn=1 in BRANCH; with Zero=0 -> PCEn=0; ALUCtr=0110 in both cases.
REQ-030 ori (001101) -> ExtZero=1 and ALUCtr=0001 in IEXEC; addi -> ExtZero=0 and ALUCtr=0010.
REQ-031 rst_n pulled low between clock edges during MEMWR -> MemWrite=0 and State=15 before the next edge; recovery follows REQ-025.
